// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default bit timing, deframer state codes.
// Latency: n/a. Backpressure: n/a.
// Used by the transmitter, the receive deframer and their benches.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 15;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

    // High when data plus received parity bit disagree with the selected parity sense.
    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p, input logic odd);
        return (^d) ^ p ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for one asynchronous input, resets to the idle-high level.
// Latency: 2 cycles. Backpressure: none.
module uart_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: start validation, mid-bit sampling, stop check; optional parity via UART_RX_PARITY_EN.
// Latency: rx_valid ~2 + HALF_BIT + 9*CLKS_PER_BIT cycles after the start edge.
// Backpressure: none, consumer must take rx_data on the rx_valid cycle.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 data_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0]    AFTER_DATA = ST_PARITY;
`else
    localparam logic [2:0]    AFTER_DATA = ST_STOP;
`endif

    logic                 rxs;
    logic [2:0]           state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 bit_tick;
    logic                 par_ok;

    uart_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (data_in),
        .q     (rxs)
    );

    assign bit_tick = (cnt == BIT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (!rxs) state_nxt = ST_START;
            ST_START:     if (cnt == HALF_LAST) state_nxt = rxs ? ST_IDLE : ST_DATA;
            ST_DATA:      if (bit_tick && bit_idx == IDX_LAST) state_nxt = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
            ST_PARITY:    if (bit_tick) state_nxt = ST_STOP;
`endif
            ST_STOP:      if (bit_tick) state_nxt = rxs ? ST_IDLE : ST_WAIT_HIGH;
            ST_WAIT_HIGH: if (rxs) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= state == ST_STOP && bit_tick && rxs && par_bad;
            if (state == ST_IDLE)
                par_bad <= 1'b0;
            else if (state == ST_PARITY && bit_tick)
                par_bad <= parity_bad(shreg, rxs, PARITY_ODD);
        end
    end

    assign par_ok = !par_bad;
`else
    assign par_ok     = 1'b1;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            busy      <= state_nxt != ST_IDLE;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            // Every state change and every completed bit period restarts the bit timer.
            if (state_nxt != state || bit_tick)
                cnt <= '0;
            else if (state != ST_IDLE && state != ST_WAIT_HIGH)
                cnt <= cnt + 1'b1;

            if (state_nxt != state)
                bit_idx <= '0;
            else if (state == ST_DATA && bit_tick)
                bit_idx <= bit_idx + 1'b1;

            if (state == ST_DATA && bit_tick)
                shreg <= {rxs, shreg[DATA_BITS-1:1]};

            if (state == ST_STOP && bit_tick) begin
                if (!rxs) begin
                    frame_err <= 1'b1;
                end else if (par_ok) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer: directed frames push expected pulses, a monitor pops and compares.
module tb_uart_rx_deframer;
    import uart_pkg::*;

    localparam int CPB  = DEFAULT_CLKS_PER_BIT;
    localparam int HALF = CPB / 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       data_in;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, busy;

    typedef struct {
        logic [2:0] kind;   // {parity_err, frame_err, rx_valid}
        logic [7:0] dat;
    } exp_t;

    exp_t       exp_q[$];
    int         valid_cyc[$];
    int         checks = 0;
    int         passes = 0;
    int         cyc    = 0;
    logic [7:0] last_good = 8'h00;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_deframer #(
        .CLKS_PER_BIT (CPB)
`ifdef UART_RX_PARITY_EN
        ,
        .PARITY_ODD   (1'b0)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic has_par = 1'b0,
                              input logic par = 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (has_par) send_bit(par);
        send_bit(stop);
    endtask

    task automatic exp_good(input logic [7:0] d);
        exp_t e;
        e.kind = 3'b001; e.dat = d;
        exp_q.push_back(e);
        last_good = d;
    endtask

    task automatic exp_ferr();
        exp_t e;
        e.kind = 3'b010; e.dat = last_good;
        exp_q.push_back(e);
    endtask

    task automatic exp_perr();
        exp_t e;
        e.kind = 3'b100; e.dat = last_good;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        data_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: every output pulse must match the head of the expectation queue.
    initial begin
        logic prev_pulse;
        logic pulse;
        exp_t e;
        prev_pulse = 1'b0;
        forever begin
            @(negedge clk);
            pulse = rx_valid | frame_err | parity_err;
            if (pulse) begin
                check("pulse_not_consecutive", {31'd0, prev_pulse}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {29'd0, parity_err, frame_err, rx_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", {29'd0, parity_err, frame_err, rx_valid}, {29'd0, e.kind});
                    check("pulse_rx_data", {24'd0, rx_data}, {24'd0, e.dat});
                end
                if (rx_valid) valid_cyc.push_back(cyc);
            end
            prev_pulse = pulse;
        end
    end

    initial begin
        reset   = 1'b0;
        data_in = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_rx_data", {24'd0, rx_data}, 32'h00);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_parity_err", {31'd0, parity_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        idle(10);

        // Single good frame
        exp_good(8'hE3);
        send_frame(8'hE3, 1'b1);
        idle(10);
        drain("drain_single");
        check("busy_after_frame", {31'd0, busy}, 32'd0);
        check("rx_data_held", {24'd0, rx_data}, 32'hE3);

        // Back-to-back frames
        valid_cyc.delete();
        for (int i = 0; i < 20; i++) exp_good(8'hE3);
        for (int i = 0; i < 20; i++) send_frame(8'hE3, 1'b1);
        idle(20);
        drain("drain_b2b");
        check("b2b_count", valid_cyc.size(), 20);
        for (int i = 1; i < valid_cyc.size(); i++)
            check("b2b_spacing", valid_cyc[i] - valid_cyc[i-1], 150);

        // Start-bit glitch
        data_in = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy_high", {31'd0, busy}, 32'd1);
        @(negedge clk);
        idle(HALF + 3 + 2);
        check("glitch_busy_low", {31'd0, busy}, 32'd0);
        idle(20);

        // Framing error, break, recovery
        exp_ferr();
        send_frame(8'h55, 1'b0);
        data_in = 1'b0;
        repeat (40) @(negedge clk);
        idle(20);
        drain("drain_ferr");
        check("ferr_rx_data_hold", {24'd0, rx_data}, 32'hE3);
        check("ferr_busy_low", {31'd0, busy}, 32'd0);
        exp_good(8'hA5);
        send_frame(8'hA5, 1'b1);
        idle(10);
        drain("drain_after_ferr");
        check("after_ferr_rx_data", {24'd0, rx_data}, 32'hA5);

        // Reset mid-DATA of 0x3C, then a fresh frame
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        reset   = 1'b0;
        data_in = 1'b1;
        repeat (5) @(negedge clk);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        last_good = 8'h00;
        idle(CPB * 8);
        check("midreset_rx_data", {24'd0, rx_data}, 32'h00);
        exp_good(8'hC3);
        send_frame(8'hC3, 1'b1);
        idle(10);
        drain("drain_after_reset");
        check("after_reset_rx_data", {24'd0, rx_data}, 32'hC3);

`ifdef UART_RX_PARITY_EN
        exp_good(8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        idle(10);
        exp_perr();
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        idle(10);
        drain("drain_parity");
        check("parity_rx_data", {24'd0, rx_data}, 32'h07);
`endif

        idle(20);
        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Serial receive front end of the UART + checker path. Sits directly upstream of the byte checker.
- Synchronises the raw asynchronous line `data_in` and detects and validates the start bit.
- Samples 8 data bits LSB-first at mid-bit, then checks the stop bit.
- Delivers each good byte as a one-cycle `rx_valid` strobe with `rx_data` held stable. Reports framing errors separately.

Parameters:
- CLKS_PER_BIT, 15, clock cycles per bit period; legal values are ≥ 4.
- HALF_BIT, CLKS_PER_BIT/2 (integer floor), cycles from start-edge detection to the start-bit mid-sample.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- data_in  in  1  raw serial line; idles high; asynchronous to clk
- rx_data  out  8  last correctly received byte; held until the next good byte
- rx_valid  out  1  one-cycle pulse when rx_data has just been updated
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low
- parity_err  out  1  one-cycle pulse on parity mismatch; tied 0 without the optional feature
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset and interface:
  - Reset (reset=0) acts asynchronously and forces: state=IDLE, both synchroniser flops=1, counters=0, shift register=0, rx_data=8'h00, rx_valid=0, frame_err=0, parity_err=0, busy=0.
  - Reset mid-frame abandons the frame. After release the block waits in IDLE for a new falling edge.
  - `data_in` passes through a 2-FF synchroniser. All logic uses only the synchronised bit `rxs`, which has 2 cycles of latency.
  - All outputs are registered. There is no back-pressure: the consumer must accept the byte on the rx_valid cycle.
- State IDLE:
  - rxs=0 → START with bit counter cleared. Otherwise remain in IDLE.
- State START:
  - The counter runs 0..HALF_BIT-1, and rxs is sampled at HALF_BIT-1.
  - Sample=1 is a glitch → IDLE with no output pulse.
  - Sample=0 → DATA with counter=0 and bit index=0.
- State DATA:
  - Sample rxs when the counter reaches CLKS_PER_BIT-1, then clear the counter.
  - Shift the sample in at bit[7] and shift right, giving LSB-first assembly.
  - After the 8th sample → STOP, or PARITY if the feature is enabled.
- State STOP:
  - Sample at CLKS_PER_BIT-1.
  - Sample=1: on that same edge rx_data←shift register and rx_valid=1 for exactly one cycle → IDLE.
  - Sample=0: frame_err=1 for one cycle, rx_data unchanged → WAIT_HIGH.
- State WAIT_HIGH:
  - Stay until rxs=1 → IDLE. This prevents a held-low line (break) from retriggering frames or pulsing errors repeatedly.
- Timing:
  - Back-to-back frames are supported. IDLE is re-entered at mid-stop-bit, so the next start edge arriving half a bit later is caught.
  - Latency: rx_valid asserts (2 + HALF_BIT + 9·CLKS_PER_BIT) clock edges after the falling edge of the start bit reaches data_in, ±1 cycle of synchroniser phase.
  - rx_valid, frame_err and parity_err are mutually exclusive and never assert in consecutive cycles.
- Counters:
  - Bit counter width is $clog2(CLKS_PER_BIT). Bit index is 3 bits.
  - No counter may wrap outside its state; each is cleared on every state entry.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds parameter PARITY_ODD (default 0 = even parity).
  - Adds state PARITY between DATA and STOP, sampled at CLKS_PER_BIT-1.
  - On a mismatch, record it. At the stop sample, if the stop bit is 1, pulse parity_err instead of rx_valid and leave rx_data unchanged.
  - Framing error takes priority over parity error.
- Undefined:
  - No PARITY state and parity_err is constant 0.
  - The frame is exactly 10 bits.

Decomposition:
- Shared package uart_pkg:
  - State encoding: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - DATA_BITS=8.
  - DEFAULT_CLKS_PER_BIT=15, shared with the UART transmitter and the testbench.
- One natural sub-module: uart_sync2, a 2-FF synchroniser with asynchronous active-low reset to 1. It is reused on every asynchronous input in the top level.

Test Plan (CLKS_PER_BIT=15, clk period 20 ns, bit 300 ns):
1. Reset low 100 ns, line high → all outputs at reset values. Then send frame 0xE3 (start 0, bits 1,1,0,0,0,1,1,1, stop 1) → rx_data=8'hE3, rx_valid high exactly 1 cycle, frame_err=0, busy low afterwards.
2. 20 back-to-back 0xE3 frames with no idle gap → exactly 20 rx_valid pulses spaced 150 cycles apart, each with rx_data=8'hE3.
3. Low glitch of 5 cycles on an idle line → no pulses. busy drops within HALF_BIT+3 cycles.
4. Send 0x55 with stop bit 0, line held low 40 cycles then high → one frame_err pulse, no rx_valid, rx_data keeps its prior value. The next 0xA5 frame is received correctly.
5. Assert reset mid-DATA of a 0x3C frame, release, then send 0xC3 → no pulse for the aborted frame; rx_data=8'hC3 after the new frame.
6. With UART_RX_PARITY_EN and PARITY_ODD=0: 0x07 with parity 1 → rx_valid. Same byte with parity 0 → parity_err only, rx_data unchanged.
